pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined main control for the 5-stage RV32 core. Decodes the ID-stage opcode
//  and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards (stall plus bubble) and applies branch/jump flushes.
//  Optional JAL/JALR/AUIPC decode; saturating illegal-opcode counter.
// PARAMETERS
//  REG_AW  5  register-index width
//  EXT_EN  1  1: decode JAL(1101111), JALR(1100111), AUIPC(0010111); 0: treat them as illegal
//  CNT_W   8  illegal-opcode counter width
// PORTS
//  clk           in   1       core clock; all state changes on the rising edge
//  reset         in   1       asynchronous, active-low
//  id_opcode     in   7       opcode of the instruction in ID
//  id_valid      in   1       ID holds a real instruction; 0 decodes as a bubble
//  id_rs1        in   REG_AW  ID source register 1
//  id_rs2        in   REG_AW  ID source register 2
//  id_rd         in   REG_AW  ID destination register
//  ex_taken      in   1       branch/jump resolved taken in EX this cycle
//  stall         out  1       hold PC and IF/ID (combinational)
//  flush         out  1       zero IF/ID (combinational, = ex_taken)
//  ex_alusrc     out  1       EX-stage ALU operand-B select
//  ex_aluop      out  2       EX-stage ALU op: 00 add, 01 branch, 10 R/I, 11 LUI
//  ex_branch     out  1       EX-stage conditional branch
//  ex_jump       out  1       EX-stage JAL/JALR
//  mem_memread   out  1       MEM-stage load
//  mem_memwrite  out  1       MEM-stage store
//  wb_regwrite   out  1       WB-stage register write enable
//  wb_memtoreg   out  1       WB-stage writeback select (1 = memory)
//  wb_rd         out  REG_AW  WB-stage destination register
//  illegal_cnt   out  CNT_W   count of valid illegal opcodes seen
// BEHAVIOUR
//  Decode (comb.), all fields 0 when id_valid=0:
//   R 0110011: regwrite, aluop=10
//   I 0010011: alusrc, regwrite, aluop=10
//   LW 0000011: alusrc, memread, memtoreg, regwrite, aluop=00
//   SW 0100011: alusrc, memwrite, aluop=00
//   BEQ 1100011: branch, aluop=01
//   LUI 0110111: alusrc, regwrite, aluop=11
//   EXT_EN=1 only:
//    JAL/JALR: jump, regwrite, aluop=00; JALR also sets alusrc
//    AUIPC: alusrc, regwrite, aluop=00
//   Any other opcode: all fields 0; illegal=1.
//  Bundle = decoded fields plus id_rd, rs2_used (R, SW, BEQ) and illegal.
//  Pipeline: fields of an instruction decoded in cycle n appear on ex_* in n+1,
//   mem_* in n+2 and wb_* in n+3. EX/MEM and MEM/WB advance every cycle.
//  Load-use hazard (comb.): stall=1 when all three hold:
//   - ID/EX.memread=1
//   - ID/EX.rd != 0
//   - ID/EX.rd == id_rs1, or (rs2_used and ID/EX.rd == id_rs2)
//  While stall=1, ID/EX loads a bubble (all zero). Upstream holds ID, so the
//   load-use stall lasts exactly 1 cycle.
//  Flush: ex_taken=1 gives flush=1, forces stall=0 (flush wins) and loads a
//   bubble into ID/EX. Instructions already in EX/MEM and beyond are unaffected.
//  illegal_cnt: +1 on each rising edge where the instruction entering ID/EX is
//   valid and illegal (not stalled, not flushed). Saturates at 2^CNT_W-1.
//  Reset (async, active-low): all stage registers, all outputs and illegal_cnt
//   go to 0 immediately. The first edge after release loads ID/EX normally.
//  Reset asserted mid-stall or mid-flush: all state is cleared; no state survives.
// TESTING
//  T1: LW (rd=5), then ADD (rs1=5) -> stall=1 for 1 cycle; ex_* zero the next
//   cycle; ADD's ex_aluop=10 one cycle later; wb_rd=5 with wb_memtoreg=1 at n+3.
//  T2: LW rd=0, then ADD rs1=0 -> stall stays 0. LW rd=7, then I-type with
//   rs2=7 -> stall stays 0 (rs2 unused).
//  T3: BEQ in EX with ex_taken=1 while a load-use hazard is present in ID ->
//   flush=1, stall=0, ex_* all 0 on the next cycle.
//  T4: EXT_EN=0 with opcode 1101111 -> all control 0, illegal_cnt +1.
//   EXT_EN=1 -> ex_jump=1, wb_regwrite=1 at n+3. CNT_W=2, 5 illegal opcodes ->
//   illegal_cnt sticks at 3.
//  T5: stream R, I, SW, LUI -> per-stage outputs match the decode table at
//   n+1/n+2/n+3; SW never asserts wb_regwrite.
//  T6: pulse reset low between clock edges mid-stream -> all outputs 0 at once,
//   without waiting for an edge; decoding restarts correctly after release.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control for the 5-stage RV32 core: ID decode, ID/EX-EX/MEM-MEM/WB
// control registers, load-use stall, branch/jump flush and a saturating illegal-opcode counter.
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int EXT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        id_opcode,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_taken,
    output logic              stall,
    output logic              flush,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic              dec_alusrc, dec_branch, dec_jump, dec_memread, dec_memwrite;
    logic              dec_regwrite, dec_memtoreg, dec_rs2_used, dec_illegal;
    logic [1:0]        dec_aluop;
    logic              hazard, bubble;
    logic [CNT_W-1:0]  cnt_d;

    logic              ex_alusrc_q, ex_branch_q, ex_jump_q, ex_memread_q, ex_memwrite_q;
    logic              ex_regwrite_q, ex_memtoreg_q;
    logic [1:0]        ex_aluop_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              mem_memread_q, mem_memwrite_q, mem_regwrite_q, mem_memtoreg_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_regwrite_q, wb_memtoreg_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        dec_alusrc   = 1'b0;
        dec_aluop    = 2'b00;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_rs2_used = 1'b0;
        dec_illegal  = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OP_R:   begin dec_regwrite = 1'b1; dec_aluop = 2'b10; dec_rs2_used = 1'b1; end
                OP_I:   begin dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_aluop = 2'b10; end
                OP_LW:  begin
                    dec_alusrc   = 1'b1;
                    dec_memread  = 1'b1;
                    dec_memtoreg = 1'b1;
                    dec_regwrite = 1'b1;
                end
                OP_SW:  begin dec_alusrc = 1'b1; dec_memwrite = 1'b1; dec_rs2_used = 1'b1; end
                OP_BEQ: begin dec_branch = 1'b1; dec_aluop = 2'b01; dec_rs2_used = 1'b1; end
                OP_LUI: begin dec_alusrc = 1'b1; dec_regwrite = 1'b1; dec_aluop = 2'b11; end
                OP_JAL, OP_JALR: begin
                    if (EXT_EN != 0) begin
                        dec_jump     = 1'b1;
                        dec_regwrite = 1'b1;
                        dec_alusrc   = (id_opcode == OP_JALR);
                    end else begin
                        dec_illegal  = 1'b1;
                    end
                end
                OP_AUIPC: begin
                    if (EXT_EN != 0) begin
                        dec_alusrc   = 1'b1;
                        dec_regwrite = 1'b1;
                    end else begin
                        dec_illegal  = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Flush overrides the load-use stall, but both still turn the ID/EX load into a bubble.
    assign hazard = ex_memread_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (dec_rs2_used && (ex_rd_q == id_rs2)));
    assign stall  = hazard && !ex_taken;
    assign flush  = ex_taken && reset;
    assign bubble = hazard || ex_taken;
    assign cnt_d  = (dec_illegal && !bubble && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_alusrc_q    <= 1'b0;
            ex_aluop_q     <= 2'b00;
            ex_branch_q    <= 1'b0;
            ex_jump_q      <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_memwrite_q  <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memtoreg_q  <= 1'b0;
            ex_rd_q        <= '0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= '0;
            cnt_q          <= '0;
        end else begin
            ex_alusrc_q    <= dec_alusrc   && !bubble;
            ex_aluop_q     <= bubble ? 2'b00 : dec_aluop;
            ex_branch_q    <= dec_branch   && !bubble;
            ex_jump_q      <= dec_jump     && !bubble;
            ex_memread_q   <= dec_memread  && !bubble;
            ex_memwrite_q  <= dec_memwrite && !bubble;
            ex_regwrite_q  <= dec_regwrite && !bubble;
            ex_memtoreg_q  <= dec_memtoreg && !bubble;
            ex_rd_q        <= (bubble || !id_valid) ? '0 : id_rd;
            mem_memread_q  <= ex_memread_q;
            mem_memwrite_q <= ex_memwrite_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memtoreg_q <= ex_memtoreg_q;
            mem_rd_q       <= ex_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_rd_q        <= mem_rd_q;
            cnt_q          <= cnt_d;
        end
    end

    assign ex_alusrc    = ex_alusrc_q;
    assign ex_aluop     = ex_aluop_q;
    assign ex_branch    = ex_branch_q;
    assign ex_jump      = ex_jump_q;
    assign mem_memread  = mem_memread_q;
    assign mem_memwrite = mem_memwrite_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_memtoreg  = wb_memtoreg_q;
    assign wb_rd        = wb_rd_q;
    assign illegal_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: default instance plus an EXT_EN=0 / CNT_W=2 instance on shared stimulus.
module tb_pipe_ctrl_unit;
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch, jump, memread, memwrite, regwrite, memtoreg, illegal;
        logic [4:0] rd;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic       valid;
        logic [4:0] rs1, rs2, rd;
        logic       taken;
        logic       stall;
    } vec_t;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, AUIPC = 7'b0010111, ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] id_opcode;
    logic       id_valid, ex_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic       stall_a, flush_a, ex_alusrc_a, ex_branch_a, ex_jump_a, mem_memread_a, mem_memwrite_a;
    logic       wb_regwrite_a, wb_memtoreg_a;
    logic [1:0] ex_aluop_a;
    logic [4:0] wb_rd_a;
    logic [7:0] cnt_a;
    logic       stall_n, flush_n, ex_alusrc_n, ex_branch_n, ex_jump_n, mem_memread_n, mem_memwrite_n;
    logic       wb_regwrite_n, wb_memtoreg_n;
    logic [1:0] ex_aluop_n;
    logic [4:0] wb_rd_n;
    logic [1:0] cnt_n;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    ctl_t        qa[$];
    ctl_t        qn[$];
    logic [7:0]  cnt_a_m;
    logic [1:0]  cnt_n_m;
    vec_t        vt[$];

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .EXT_EN(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
        .stall(stall_a), .flush(flush_a), .ex_alusrc(ex_alusrc_a), .ex_aluop(ex_aluop_a),
        .ex_branch(ex_branch_a), .ex_jump(ex_jump_a), .mem_memread(mem_memread_a),
        .mem_memwrite(mem_memwrite_a), .wb_regwrite(wb_regwrite_a), .wb_memtoreg(wb_memtoreg_a),
        .wb_rd(wb_rd_a), .illegal_cnt(cnt_a)
    );

    pipe_ctrl_unit #(.REG_AW(5), .EXT_EN(0), .CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
        .stall(stall_n), .flush(flush_n), .ex_alusrc(ex_alusrc_n), .ex_aluop(ex_aluop_n),
        .ex_branch(ex_branch_n), .ex_jump(ex_jump_n), .mem_memread(mem_memread_n),
        .mem_memwrite(mem_memwrite_n), .wb_regwrite(wb_regwrite_n), .wb_memtoreg(wb_memtoreg_n),
        .wb_rd(wb_rd_n), .illegal_cnt(cnt_n)
    );

    function automatic vec_t mk(logic [6:0] op, logic valid, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic taken, logic stall);
        vec_t v;
        v.op = op; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.taken = taken; v.stall = stall;
        return v;
    endfunction

    // Expected control word from the opcode table (ext=0 models the EXT_EN=0 instance).
    function automatic ctl_t ref_ctl(vec_t v, bit ext);
        ctl_t c = '0;
        if (!v.valid) return c;
        c.rd = v.rd;
        case (v.op)
            R:     begin c.regwrite = 1'b1; c.aluop = 2'b10; end
            I:     begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b10; end
            LW:    begin c.alusrc = 1'b1; c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            SW:    begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
            BEQ:   begin c.branch = 1'b1; c.aluop = 2'b01; end
            LUI:   begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b11; end
            JAL:   if (ext) begin c.jump = 1'b1; c.regwrite = 1'b1; end else c.illegal = 1'b1;
            JALR:  if (ext) begin c.jump = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; end
                   else c.illegal = 1'b1;
            AUIPC: if (ext) begin c.alusrc = 1'b1; c.regwrite = 1'b1; end else c.illegal = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete(); qn.delete();
        repeat (3) begin qa.push_back('0); qn.push_back('0); end
        cnt_a_m = '0;
        cnt_n_m = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'({stall_a, stall_n}), 32'd0);
        chk({tag, "_a_ctl"}, 32'({ex_alusrc_a, ex_aluop_a, ex_branch_a, ex_jump_a, mem_memread_a,
                                  mem_memwrite_a, wb_regwrite_a, wb_memtoreg_a, wb_rd_a}), 32'd0);
        chk({tag, "_n_ctl"}, 32'({ex_alusrc_n, ex_aluop_n, ex_branch_n, ex_jump_n, mem_memread_n,
                                  mem_memwrite_n, wb_regwrite_n, wb_memtoreg_n, wb_rd_n}), 32'd0);
        chk({tag, "_cnt"}, 32'({cnt_a, cnt_n}), 32'd0);
    endtask

    // Drive one ID-stage instruction, check the combinational hazard outputs, then the stages.
    task automatic step(input vec_t v);
        ctl_t ca, cn, e;
        @(negedge clk);
        id_opcode = v.op; id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rd = v.rd; ex_taken = v.taken;
        #1;
        chk("stall_a", 32'(stall_a), 32'(v.stall));
        chk("stall_n", 32'(stall_n), 32'(v.stall));
        chk("flush", 32'({flush_a, flush_n}), 32'({v.taken, v.taken}));
        ca = ref_ctl(v, 1'b1);
        cn = ref_ctl(v, 1'b0);
        if (v.stall || v.taken) begin
            ca = '0;
            cn = '0;
        end
        if (ca.illegal && cnt_a_m != 8'hFF) cnt_a_m = cnt_a_m + 8'd1;
        if (cn.illegal && cnt_n_m != 2'b11) cnt_n_m = cnt_n_m + 2'd1;
        qa.push_back(ca); qn.push_back(cn);
        void'(qa.pop_front()); void'(qn.pop_front());
        @(posedge clk);
        #1;
        e = qa[2];
        chk("ex_a", 32'({ex_alusrc_a, ex_aluop_a, ex_branch_a, ex_jump_a}),
            32'({e.alusrc, e.aluop, e.branch, e.jump}));
        e = qa[1];
        chk("mem_a", 32'({mem_memread_a, mem_memwrite_a}), 32'({e.memread, e.memwrite}));
        e = qa[0];
        chk("wb_a", 32'({wb_regwrite_a, wb_memtoreg_a, wb_rd_a}), 32'({e.regwrite, e.memtoreg, e.rd}));
        chk("cnt_a", 32'(cnt_a), 32'(cnt_a_m));
        e = qn[2];
        chk("ex_n", 32'({ex_alusrc_n, ex_aluop_n, ex_branch_n, ex_jump_n}),
            32'({e.alusrc, e.aluop, e.branch, e.jump}));
        chk("memwb_n", 32'({mem_memread_n, mem_memwrite_n, wb_regwrite_n, wb_memtoreg_n}),
            32'({qn[1].memread, qn[1].memwrite, qn[0].regwrite, qn[0].memtoreg}));
        chk("cnt_n", 32'(cnt_n), 32'(cnt_n_m));
    endtask

    initial begin
        //                op     v  rs1 rs2 rd  tk stall
        vt.push_back(mk(R,     1, 1,  2,  3,  0, 0));
        vt.push_back(mk(I,     1, 3,  4,  4,  0, 0));
        vt.push_back(mk(SW,    1, 4,  3,  0,  0, 0));
        vt.push_back(mk(LUI,   1, 0,  0,  6,  0, 0));
        vt.push_back(mk(LW,    1, 1,  0,  5,  0, 0));
        vt.push_back(mk(R,     1, 5,  2,  8,  0, 1));
        vt.push_back(mk(R,     1, 5,  2,  8,  0, 0));
        vt.push_back(mk(LW,    1, 2,  0,  0,  0, 0));
        vt.push_back(mk(R,     1, 0,  0,  9,  0, 0));
        vt.push_back(mk(LW,    1, 1,  0,  7,  0, 0));
        vt.push_back(mk(I,     1, 1,  7,  10, 0, 0));
        vt.push_back(mk(LW,    1, 1,  0,  11, 0, 0));
        vt.push_back(mk(SW,    1, 1,  11, 0,  0, 1));
        vt.push_back(mk(SW,    1, 1,  11, 0,  0, 0));
        vt.push_back(mk(LW,    1, 1,  0,  12, 0, 0));
        vt.push_back(mk(R,     1, 12, 1,  13, 1, 0));
        vt.push_back(mk(BEQ,   1, 1,  2,  0,  0, 0));
        vt.push_back(mk(R,     1, 1,  2,  14, 1, 0));
        vt.push_back(mk(I,     1, 1,  0,  15, 0, 0));
        vt.push_back(mk(LW,    1, 1,  0,  20, 0, 0));
        vt.push_back(mk(BEQ,   1, 3,  20, 0,  1, 0));
        vt.push_back(mk(R,     1, 20, 1,  16, 0, 0));
        vt.push_back(mk(JAL,   1, 0,  0,  1,  0, 0));
        vt.push_back(mk(JALR,  1, 2,  0,  2,  0, 0));
        vt.push_back(mk(AUIPC, 1, 0,  0,  3,  0, 0));
        repeat (5) vt.push_back(mk(ILL, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(ILL,   0, 0,  0,  0,  0, 0));
        vt.push_back(mk(R,     1, 1,  2,  17, 0, 0));
        repeat (3) vt.push_back(mk(7'd0, 0, 0, 0, 0, 0, 0));

        reset = 1'b0; id_opcode = '0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_rd = '0; ex_taken = 1'b0;
        model_reset();
        #1 chk_all_zero("por");
        @(posedge clk); #2 reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // Reset pulse while a load-use stall is being raised; nothing may survive it.
        step(mk(LW, 1, 1, 0, 5, 0, 0));
        @(negedge clk);
        id_opcode = R; id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd2; id_rd = 5'd8; ex_taken = 1'b0;
        #1 chk("pre_rst_stall", 32'({stall_a, stall_n}), 32'b11);
        #2 reset = 1'b0;
        #1 chk_all_zero("rst_mid");
        @(posedge clk); #2 reset = 1'b1;
        model_reset();
        step(mk(R,  1, 5, 2, 8, 0, 0));
        step(mk(I,  1, 1, 0, 4, 0, 0));
        step(mk(LW, 1, 1, 0, 9, 0, 0));
        step(mk(SW, 1, 2, 9, 0, 0, 1));
        step(mk(SW, 1, 2, 9, 0, 0, 0));
        step(mk(ILL, 1, 0, 0, 0, 0, 0));
        repeat (3) step(mk(7'd0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
